// File: rtl/instr_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : instr_issue_ctrl
// Brief    : Fetch/issue sequencer. It fetches one instruction word, presents
//            it to the decoder for a single cycle, and then waits for the
//            vector engine or for the wfi/done handshake. Optional macro:
//            ISSUE_PERF_CNT_EN adds saturating issue and stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module instr_issue_ctrl #(
    parameter int PC_W    = 10,
    parameter int DW_INST = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               imem_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [DW_INST-1:0] imem_rdata,
    output logic [DW_INST-1:0] instr,
    output logic               instr_valid,
    input  logic               is_not_vect,
    input  logic               vec_done,
    input  logic               is_bne,
    input  logic               branch_taken,
    input  logic [11:0]        branch_immediate,
    input  logic               ap_done,
    output logic               busy,
    output logic               done
`ifdef ISSUE_PERF_CNT_EN
    ,
    output logic [31:0]        issue_cnt,
    output logic [31:0]        stall_cnt
`endif
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_fetch = 3'd1;
    localparam logic [2:0] c_st_issue = 3'd2;
    localparam logic [2:0] c_st_vwait = 3'd3;
    localparam logic [2:0] c_st_wfi   = 3'd4;
    localparam logic [2:0] c_st_done  = 3'd5;

    localparam logic [DW_INST-1:0] c_wfi    = DW_INST'(32'h10500073);
    localparam logic [PC_W-1:0]    c_pc_one = PC_W'(1);

    logic [2:0]         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [DW_INST-1:0] instr_q, instr_d;
    logic               vec_seen_q, vec_seen_d;
    logic               done_q, done_d;

    logic               start_acc;
    logic [31:0]        br_off;

    assign start_acc = start && ((state_q == c_st_idle) || (state_q == c_st_done));

    // Branch offset is the signed immediate halved (arithmetic), sign-extended.
    assign br_off = {{21{branch_immediate[11]}}, branch_immediate[11:1]};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        vec_seen_d = vec_seen_q;
        done_d     = 1'b0;
        case (state_q)
            c_st_idle, c_st_done: begin
                if (start_acc) begin
                    state_d = c_st_fetch;
                    pc_d    = '0;
                end
            end
            c_st_fetch: begin
                state_d = c_st_issue;
                instr_d = imem_rdata;
            end
            c_st_issue: begin
                vec_seen_d = 1'b0;
                if (instr_q == c_wfi) begin
                    if (ap_done) begin
                        state_d = c_st_done;
                        done_d  = 1'b1;
                    end else begin
                        state_d = c_st_wfi;
                    end
                end else if (!is_not_vect) begin
                    state_d = c_st_vwait;
                    pc_d    = pc_q + c_pc_one;
                    // An early completion is remembered so VWAIT lasts one cycle.
                    vec_seen_d = vec_done;
                end else if (is_bne && branch_taken) begin
                    state_d = c_st_fetch;
                    pc_d    = pc_q + br_off[PC_W-1:0];
                end else begin
                    state_d = c_st_fetch;
                    pc_d    = pc_q + c_pc_one;
                end
            end
            c_st_vwait: begin
                if (vec_done || vec_seen_q) begin
                    state_d    = c_st_fetch;
                    vec_seen_d = 1'b0;
                end
            end
            c_st_wfi: begin
                if (ap_done) begin
                    state_d = c_st_done;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d    = c_st_idle;
                vec_seen_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= c_st_idle;
            pc_q       <= '0;
            instr_q    <= '0;
            vec_seen_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            vec_seen_q <= vec_seen_d;
            done_q     <= done_d;
        end
    end

    assign imem_en     = (state_q == c_st_fetch);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == c_st_issue);
    assign busy        = (state_q != c_st_idle) && (state_q != c_st_done);
    assign done        = done_q;

`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] issue_cnt_q, issue_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        issue_cnt_d = issue_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (start_acc) begin
            issue_cnt_d = '0;
            stall_cnt_d = '0;
        end else begin
            if ((state_q == c_st_issue) && (issue_cnt_q != 32'hFFFF_FFFF)) begin
                issue_cnt_d = issue_cnt_q + 32'd1;
            end
            if (((state_q == c_st_vwait) || (state_q == c_st_wfi)) &&
                (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign issue_cnt = issue_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire
